execute_feedback_ready_table: RTL and testbench

//  Consumer end of the execute feedback pack: tracks a ready bit per physical register.
//  - Rename clears a register's bit when it allocates it as a destination.
//  - Execute feedback channels set the bit when the result is produced.
//  - Issue-side query ports read the bits, with same-cycle feedback bypass.
//  - Sits between the execute feedback aggregation and the issue/wakeup logic.

---
 rtl/execute_feedback_ready_table.sv | 90 +++++++++
 tb/tb_execute_feedback_ready_table.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_feedback_ready_table.sv
// Ready bit per physical register: rename clears, execute feedback sets, issue queries read
// with same-cycle feedback bypass. Register 0 is permanently ready.
module execute_feedback_ready_table #(
  parameter int  PHY_REG_NUM    = 64,
  parameter int  FB_CHANNEL_NUM = 9,
  parameter int  RENAME_WIDTH   = 4,
  parameter int  QUERY_NUM      = 8,
  localparam int PW             = $clog2(PHY_REG_NUM)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [FB_CHANNEL_NUM-1:0]           i_feedback_enable,
  input  logic [FB_CHANNEL_NUM-1:0][PW-1:0]   i_feedback_phy_id,
  input  logic [RENAME_WIDTH-1:0]             i_alloc_valid,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]     i_alloc_phy_id,
  input  logic                                i_flush,
  input  logic [QUERY_NUM-1:0][PW-1:0]        i_query_phy_id,
  output logic [QUERY_NUM-1:0]                o_query_ready,
  output logic [PW:0]                         o_not_ready_count,
  output logic                                o_feedback_error
);

  logic [PHY_REG_NUM-1:0] r_ready;
  logic [PW:0]            r_not_ready_count;
  logic                   r_feedback_error;

  logic [PHY_REG_NUM-1:0] w_alloc_hit;
  logic [PHY_REG_NUM-1:0] w_fb_hit;
  logic [PHY_REG_NUM-1:0] w_ready_next;
  logic                   w_error_event;

  function automatic logic [PW:0] count_clear(input logic [PHY_REG_NUM-1:0] bits);
    logic [PW:0] n;
    n = '0;
    for (int i = 0; i < PHY_REG_NUM; i++) begin
      n = n + {{PW{1'b0}}, ~bits[i]};
    end
    return n;
  endfunction

  // Per-register hit vectors; id 0 never hits, so duplicates collapse naturally.
  always_comb begin
    w_alloc_hit = '0;
    w_fb_hit    = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_alloc_hit[i_alloc_phy_id[k]] = w_alloc_hit[i_alloc_phy_id[k]] |
                                       (i_alloc_valid[k] & (i_alloc_phy_id[k] != '0));
    end
    for (int c = 0; c < FB_CHANNEL_NUM; c++) begin
      w_fb_hit[i_feedback_phy_id[c]] = w_fb_hit[i_feedback_phy_id[c]] |
                                       (i_feedback_enable[c] & (i_feedback_phy_id[c] != '0));
    end
  end

  // Next state: flush beats allocation, allocation beats same-cycle feedback.
  always_comb begin
    if (i_flush) begin
      w_ready_next = '1;
    end else begin
      w_ready_next    = (r_ready | w_fb_hit) & ~w_alloc_hit;
      w_ready_next[0] = 1'b1;
    end
    w_error_event = ~i_flush & (|(w_fb_hit & r_ready & ~w_alloc_hit));
  end

  // Wakeup bypass: feedback this cycle is visible to the query immediately.
  always_comb begin
    o_query_ready = '0;
    for (int q = 0; q < QUERY_NUM; q++) begin
      o_query_ready[q] = r_ready[i_query_phy_id[q]] | w_fb_hit[i_query_phy_id[q]];
    end
  end

  // State registers; the error flag is sticky until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready           <= '1;
      r_not_ready_count <= '0;
      r_feedback_error  <= 1'b0;
    end else begin
      r_ready           <= w_ready_next;
      r_not_ready_count <= count_clear(w_ready_next);
      r_feedback_error  <= r_feedback_error | w_error_event;
    end
  end

  assign o_not_ready_count = r_not_ready_count;
  assign o_feedback_error  = r_feedback_error;

endmodule

// File: tb/tb_execute_feedback_ready_table.sv
// Self-checking bench: directed scenarios plus randomized traffic against a per-register rule model.
module tb_execute_feedback_ready_table;
  localparam int N  = 64;
  localparam int FB = 9;
  localparam int RW = 4;
  localparam int QN = 8;
  localparam int PW = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [FB-1:0]          fb_en;
  logic [FB-1:0][PW-1:0]  fb_id;
  logic [RW-1:0]          al_v;
  logic [RW-1:0][PW-1:0]  al_id;
  logic                   flush;
  logic [QN-1:0][PW-1:0]  q_id;
  logic [QN-1:0]          q_rdy;
  logic [PW:0]            nr_cnt;
  logic                   fb_err;

  int n_checks = 0;
  int n_errors = 0;

  bit mdl_ready [N];
  bit mdl_err;
  int mdl_count;

  always #5 clk = ~clk;

  execute_feedback_ready_table dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_feedback_enable (fb_en),
    .i_feedback_phy_id (fb_id),
    .i_alloc_valid     (al_v),
    .i_alloc_phy_id    (al_id),
    .i_flush           (flush),
    .i_query_phy_id    (q_id),
    .o_query_ready     (q_rdy),
    .o_not_ready_count (nr_cnt),
    .o_feedback_error  (fb_err)
  );

  function automatic bit model_query(input int id);
    bit hit;
    hit = (id == 0) || mdl_ready[id];
    for (int c = 0; c < FB; c++) begin
      if (fb_en[c] && int'(fb_id[c]) == id) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic model_step();
    bit nx [N];
    bit a;
    bit f;
    for (int r = 0; r < N; r++) begin
      nx[r] = mdl_ready[r];
      a = 1'b0;
      f = 1'b0;
      for (int k = 0; k < RW; k++) if (al_v[k] && int'(al_id[k]) == r) a = 1'b1;
      for (int c = 0; c < FB; c++) if (fb_en[c] && int'(fb_id[c]) == r) f = 1'b1;
      if (rst || flush || r == 0) begin
        nx[r] = 1'b1;
      end else if (a) begin
        nx[r] = 1'b0;
      end else if (f) begin
        if (mdl_ready[r]) mdl_err = 1'b1;
        nx[r] = 1'b1;
      end
    end
    if (rst) mdl_err = 1'b0;
    mdl_count = 0;
    for (int r = 0; r < N; r++) begin
      mdl_ready[r] = nx[r];
      if (!nx[r]) mdl_count++;
    end
  endtask

  task automatic clear_inputs();
    rst   = 1'b0;
    fb_en = '0;
    al_v  = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (nr_cnt !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_count got=%0d exp=0", nr_cnt);
    end
    n_checks++;
    if (fb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_error got=%b exp=0", fb_err);
    end
    for (int g = 0; g < N / QN; g++) begin
      for (int q = 0; q < QN; q++) q_id[q] = PW'(g * QN + q);
      #1;
      for (int q = 0; q < QN; q++) begin
        n_checks++;
        if (q_rdy[q] !== 1'b1) begin
          n_errors++;
          $display("FAIL reset_query id=%0d got=%b exp=1", g * QN + q, q_rdy[q]);
        end
      end
    end
  endtask

  task automatic test_alloc_feedback();
    al_v = 4'b0011; al_id[0] = 6'd5; al_id[1] = 6'd6;
    tick();
    q_id[0] = 6'd5; q_id[1] = 6'd6;
    #1;
    n_checks++;
    if (q_rdy[1:0] !== 2'b00) begin
      n_errors++;
      $display("FAIL alloc_query got=%b exp=00", q_rdy[1:0]);
    end
    n_checks++;
    if (nr_cnt !== 7'd2) begin
      n_errors++;
      $display("FAIL alloc_count got=%0d exp=2", nr_cnt);
    end
    tick();
    tick();
    fb_en[3] = 1'b1; fb_id[3] = 6'd5;
    #1;
    n_checks++;
    if (q_rdy[1:0] !== 2'b01) begin
      n_errors++;
      $display("FAIL bypass_query got=%b exp=01", q_rdy[1:0]);
    end
    tick();
    #1;
    n_checks++;
    if (q_rdy[1:0] !== 2'b01 || nr_cnt !== 7'd1) begin
      n_errors++;
      $display("FAIL feedback_set query=%b exp=01 count=%0d exp=1", q_rdy[1:0], nr_cnt);
    end
  endtask

  task automatic test_alloc_beats_feedback();
    al_v = 4'b0100; al_id[2] = 6'd9;
    fb_en[0] = 1'b1; fb_id[0] = 6'd9;
    q_id[0] = 6'd9;
    #1;
    n_checks++;
    if (q_rdy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_bypass got=%b exp=1", q_rdy[0]);
    end
    tick();
    #1;
    n_checks++;
    if (q_rdy[0] !== 1'b0 || fb_err !== 1'b0 || nr_cnt !== 7'd2) begin
      n_errors++;
      $display("FAIL alloc_wins query=%b exp=0 err=%b exp=0 count=%0d exp=2", q_rdy[0], fb_err, nr_cnt);
    end
    fb_en[1:0] = 2'b11; fb_id[0] = 6'd6; fb_id[1] = 6'd9;
    tick();
    n_checks++;
    if (nr_cnt !== 7'd0 || fb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL drain count=%0d exp=0 err=%b exp=0", nr_cnt, fb_err);
    end
  endtask

  task automatic test_flush();
    al_v = 4'b0111; al_id[0] = 6'd10; al_id[1] = 6'd11; al_id[2] = 6'd12;
    tick();
    n_checks++;
    if (nr_cnt !== 7'd3) begin
      n_errors++;
      $display("FAIL flush_pre_count got=%0d exp=3", nr_cnt);
    end
    flush = 1'b1; al_v = 4'b0001; al_id[0] = 6'd13;
    tick();
    for (int q = 0; q < 4; q++) q_id[q] = PW'(10 + q);
    #1;
    n_checks++;
    if (nr_cnt !== 7'd0 || q_rdy[3:0] !== 4'b1111) begin
      n_errors++;
      $display("FAIL flush count=%0d exp=0 query=%b exp=1111", nr_cnt, q_rdy[3:0]);
    end
  endtask

  task automatic test_error_sticky();
    fb_en[8] = 1'b1; fb_id[8] = 6'd20;
    tick();
    n_checks++;
    if (fb_err !== 1'b1) begin
      n_errors++;
      $display("FAIL error_set got=%b exp=1", fb_err);
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if (fb_err !== 1'b1) begin
      n_errors++;
      $display("FAIL error_after_flush got=%b exp=1", fb_err);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (fb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL error_after_rst got=%b exp=0", fb_err);
    end
  endtask

  task automatic test_reg_zero_and_dups();
    al_v = 4'b0001; al_id[0] = 6'd0;
    fb_en[0] = 1'b1; fb_id[0] = 6'd0;
    q_id[0] = 6'd0;
    #1;
    n_checks++;
    if (q_rdy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_query got=%b exp=1", q_rdy[0]);
    end
    tick();
    #1;
    n_checks++;
    if (q_rdy[0] !== 1'b1 || nr_cnt !== 7'd0 || fb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_ignored query=%b exp=1 count=%0d exp=0 err=%b exp=0", q_rdy[0], nr_cnt, fb_err);
    end
    al_v = 4'b1010; al_id[1] = 6'd4; al_id[3] = 6'd4;
    tick();
    n_checks++;
    if (nr_cnt !== 7'd1) begin
      n_errors++;
      $display("FAIL dup_alloc_count got=%0d exp=1", nr_cnt);
    end
    fb_en[5:4] = 2'b11; fb_id[4] = 6'd4; fb_id[5] = 6'd4;
    tick();
    n_checks++;
    if (nr_cnt !== 7'd0 || fb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL dup_feedback count=%0d exp=0 err=%b exp=0", nr_cnt, fb_err);
    end
  endtask

  task automatic test_random();
    int pend [$];
    for (int cyc = 0; cyc < 600; cyc++) begin
      pend.delete();
      for (int r = 1; r < N; r++) if (!mdl_ready[r]) pend.push_back(r);
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < RW; k++) begin
        al_v[k]  = ($urandom_range(0, 2) == 0);
        al_id[k] = PW'($urandom_range(0, N - 1));
      end
      for (int c = 0; c < FB; c++) begin
        fb_en[c] = ($urandom_range(0, 2) == 0);
        if (pend.size() > 0 && $urandom_range(0, 15) != 0)
          fb_id[c] = PW'(pend[$urandom_range(0, pend.size() - 1)]);
        else
          fb_id[c] = PW'($urandom_range(0, N - 1));
      end
      for (int q = 0; q < QN; q++) begin
        if (q < 2) q_id[q] = fb_id[$urandom_range(0, FB - 1)];
        else if (pend.size() > 0 && q < 5) q_id[q] = PW'(pend[$urandom_range(0, pend.size() - 1)]);
        else q_id[q] = PW'($urandom_range(0, N - 1));
      end
      #1;
      for (int q = 0; q < QN; q++) begin
        n_checks++;
        if (q_rdy[q] !== model_query(int'(q_id[q]))) begin
          n_errors++;
          $display("FAIL rand_query cyc=%0d port=%0d id=%0d got=%b exp=%b",
                   cyc, q, q_id[q], q_rdy[q], model_query(int'(q_id[q])));
        end
      end
      tick();
      n_checks++;
      if (nr_cnt !== 7'(mdl_count)) begin
        n_errors++;
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, nr_cnt, mdl_count);
      end
      n_checks++;
      if (fb_err !== mdl_err) begin
        n_errors++;
        $display("FAIL rand_error cyc=%0d got=%b exp=%b", cyc, fb_err, mdl_err);
      end
    end
  endtask

  initial begin
    clear_inputs();
    fb_id = '0;
    al_id = '0;
    q_id  = '0;
    test_reset();
    test_alloc_feedback();
    test_alloc_beats_feedback();
    test_flush();
    test_error_sticky();
    test_reg_zero_and_dups();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
